// File: rtl/g729_basic_op_pkg.sv
// ---------------------------------------------------------------------------
// g729_basic_op_pkg
// Shared G.729 fixed-point helpers for the LSP predictor engine.
//   - Q15/Q31 saturation constants
//   - ITU basic ops: L_mult, L_add_sat, L_sub_sat, L_shl_sat
//   - FSM state and mode enums for lsp_prev_engine
// No ports (package).
// ---------------------------------------------------------------------------
package g729_basic_op_pkg;

  localparam logic signed [31:0] MAX_32 = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] MIN_32 = 32'sh8000_0000;
  localparam logic signed [15:0] MAX_16 = 16'sh7FFF;
  localparam logic signed [15:0] MIN_16 = 16'sh8000;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_X,
    ST_RD_G,
    ST_RD_FP,
    ST_RD_FG,
    ST_MAC,
    ST_FIN,
    ST_WR,
    ST_DONE
  } lsp_prev_state_t;

  typedef enum logic {
    MODE_EXTRACT = 1'b0,
    MODE_COMPOSE = 1'b1
  } lsp_prev_mode_t;

  // Fractional multiply: 2*a*b, with the single overflow case
  // (-1 * -1) pinned to the positive limit.
  function automatic logic signed [31:0] L_mult(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
    logic signed [31:0] prod;
    if (a == MIN_16 && b == MIN_16) begin
      return MAX_32;
    end
    prod = $signed(32'(a)) * $signed(32'(b));
    return {prod[30:0], 1'b0};
  endfunction

  // Saturating 32-bit add: overflow only when both operands share a sign
  // and the result flips it.
  function automatic logic signed [31:0] L_add_sat(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
    logic signed [31:0] sum;
    sum = a + b;
    if (a[31] == b[31] && sum[31] != a[31]) begin
      return a[31] ? MIN_32 : MAX_32;
    end
    return sum;
  endfunction

  // Saturating 32-bit subtract: overflow only when operand signs differ
  // and the result takes the sign of the subtrahend.
  function automatic logic signed [31:0] L_sub_sat(input logic signed [31:0] a,
                                                   input logic signed [31:0] b);
    logic signed [31:0] diff;
    diff = a - b;
    if (a[31] != b[31] && diff[31] != a[31]) begin
      return a[31] ? MIN_32 : MAX_32;
    end
    return diff;
  endfunction

  // Saturating left shift; done in 64 bits so any overflow is visible
  // as a value outside the 32-bit range (n is expected to be < 32).
  function automatic logic signed [31:0] L_shl_sat(input logic signed [31:0] x,
                                                   input int n);
    logic signed [63:0] wide;
    wide = $signed(64'(x)) <<< n;
    if (wide > $signed(64'(MAX_32))) begin
      return MAX_32;
    end
    if (wide < $signed(64'(MIN_32))) begin
      return MIN_32;
    end
    return wide[31:0];
  endfunction

endpackage

// File: rtl/lsp_prev_engine_if.sv
// ---------------------------------------------------------------------------
// lsp_prev_engine_if
// Control + scratch-RAM bus of the LSP predictor engine.
//   start/mode         : one-cycle request and mode (0 extract, 1 compose)
//   *_base             : base addresses of x[], g[], freq_prev, fg, result
//   readAddr / readIn  : RAM read port, data valid one cycle after address
//   writeAddr/writeOut/writeEn : RAM write port
//   busy / done        : run status and completion pulse
// master = controller + RAM side, slave = engine side.
// ---------------------------------------------------------------------------
interface lsp_prev_engine_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
);

  logic              start;
  logic              mode;
  logic [ADDR_W-1:0] x_base;
  logic [ADDR_W-1:0] g_base;
  logic [ADDR_W-1:0] fp_base;
  logic [ADDR_W-1:0] fg_base;
  logic [ADDR_W-1:0] out_base;
  logic [ADDR_W-1:0] readAddr;
  logic [DATA_W-1:0] readIn;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeOut;
  logic              writeEn;
  logic              busy;
  logic              done;

  modport master (
    output start, mode, x_base, g_base, fp_base, fg_base, out_base, readIn,
    input  readAddr, writeAddr, writeOut, writeEn, busy, done
  );

  modport slave (
    input  start, mode, x_base, g_base, fp_base, fg_base, out_base, readIn,
    output readAddr, writeAddr, writeOut, writeEn, busy, done
  );

endinterface

// File: rtl/lsp_prev_engine_l_mac_sat.sv
// ---------------------------------------------------------------------------
// l_mac_sat
// Combinational L_mac / L_msu: o_result = sat32(i_acc +/- L_mult(i_a, i_b)).
//   i_acc  : 32-bit accumulator in
//   i_a    : Q15 operand a
//   i_b    : Q15 operand b
//   i_sub  : 1 = subtract (L_msu), 0 = add (L_mac)
//   o_result : saturated accumulator out
// ---------------------------------------------------------------------------
module l_mac_sat
  import g729_basic_op_pkg::*;
(
  input  logic signed [31:0] i_acc,
  input  logic signed [15:0] i_a,
  input  logic signed [15:0] i_b,
  input  logic               i_sub,
  output logic signed [31:0] o_result
);

  logic signed [31:0] w_prod;

  always_comb begin
    w_prod   = L_mult(i_a, i_b);
    o_result = i_sub ? L_sub_sat(i_acc, w_prod) : L_add_sat(i_acc, w_prod);
  end

endmodule

// File: rtl/lsp_prev_engine.sv
// ---------------------------------------------------------------------------
// lsp_prev_engine
// G.729 LSP moving-average predictor engine (Qua_Lsp).
//   Extract: out[j] = L_shl(L_mult(hi(x[j]<<16 - sum fp*fg), g[j]), SHIFT)
//   Compose: out[j] = hi(L_mult(x[j], g[j]) + sum fp*fg)
// One RAM access per cycle, 4 + 3*NP cycles per element.
// Ports:
//   clk   : clock
//   reset : synchronous active-high reset
//   bus   : lsp_prev_engine_if.slave (control, RAM read/write, status)
// ---------------------------------------------------------------------------
module lsp_prev_engine
  import g729_basic_op_pkg::*;
#(
  parameter int M      = 10,
  parameter int NP     = 4,
  parameter int SHIFT  = 3,
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32
) (
  input logic                clk,
  input logic                reset,
  lsp_prev_engine_if.slave   bus
);

  localparam int JW = $clog2(M + 1);
  localparam int KW = $clog2(NP + 1);
  localparam logic [JW-1:0] J_LAST = JW'(M - 1);
  localparam logic [KW-1:0] K_LAST = KW'(NP - 1);

  lsp_prev_state_t    r_state;
  lsp_prev_state_t    w_next;
  lsp_prev_mode_t     r_mode;
  logic [JW-1:0]      r_j;
  logic [KW-1:0]      r_k;
  logic [ADDR_W-1:0]  r_idx;
  logic signed [15:0] r_x;
  logic signed [15:0] r_g;
  logic signed [15:0] r_fp;
  logic signed [31:0] r_acc;

  logic signed [31:0] w_macAcc;
  logic signed [15:0] w_macA;
  logic signed [15:0] w_macB;
  logic               w_macSub;
  logic signed [31:0] w_macOut;
  logic signed [31:0] w_finAcc;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: one state per cycle, the only branches are the
  // start request, the end of the k loop and the end of the j loop.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = bus.start ? ST_RD_X : ST_IDLE;
      ST_RD_X:  w_next = ST_RD_G;
      ST_RD_G:  w_next = ST_RD_FP;
      ST_RD_FP: w_next = ST_RD_FG;
      ST_RD_FG: w_next = ST_MAC;
      ST_MAC:   w_next = (r_k == K_LAST) ? ST_FIN : ST_RD_FP;
      ST_FIN:   w_next = ST_WR;
      ST_WR:    w_next = (r_j == J_LAST) ? ST_DONE : ST_RD_X;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Bus outputs decoded straight from state; everything idles at zero.
  always_comb begin
    bus.readAddr  = '0;
    bus.writeAddr = '0;
    bus.writeOut  = '0;
    bus.writeEn   = 1'b0;
    bus.busy      = (r_state != ST_IDLE);
    bus.done      = (r_state == ST_DONE);
    case (r_state)
      ST_RD_X:  bus.readAddr = bus.x_base + ADDR_W'(r_j);
      ST_RD_G:  bus.readAddr = bus.g_base + ADDR_W'(r_j);
      ST_RD_FP: bus.readAddr = bus.fp_base + r_idx;
      ST_RD_FG: bus.readAddr = bus.fg_base + r_idx;
      ST_WR: begin
        bus.writeEn   = 1'b1;
        bus.writeAddr = bus.out_base + ADDR_W'(r_j);
        bus.writeOut  = {{(DATA_W-16){r_acc[31]}}, r_acc[31:16]};
      end
      default: ;
    endcase
  end

  // The single MAC unit is borrowed in RD_FP for the compose-mode
  // initialisation: acc = 0 + L_mult(x, g) with g arriving on readIn.
  // Otherwise it accumulates fp*fg, subtracting in extract mode.
  always_comb begin
    w_macAcc = r_acc;
    w_macA   = r_fp;
    w_macB   = bus.readIn[15:0];
    w_macSub = (r_mode == MODE_EXTRACT);
    if (r_state == ST_RD_FP) begin
      w_macAcc = '0;
      w_macA   = r_x;
      w_macSub = 1'b0;
    end
  end

  l_mac_sat u_mac (
    .i_acc    (w_macAcc),
    .i_a      (w_macA),
    .i_b      (w_macB),
    .i_sub    (w_macSub),
    .o_result (w_macOut)
  );

  // Extract-mode finishing step: scale the residual by g[j], then shift.
  always_comb begin
    w_finAcc = L_shl_sat(L_mult(r_acc[31:16], r_g), SHIFT);
  end

  // Datapath registers. idx is a running j*NP+k counter, so it is only
  // cleared at start and never recomputed from j.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mode <= MODE_EXTRACT;
      r_j    <= '0;
      r_k    <= '0;
      r_idx  <= '0;
      r_x    <= '0;
      r_g    <= '0;
      r_fp   <= '0;
      r_acc  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_mode <= lsp_prev_mode_t'(bus.mode);
            r_j    <= '0;
            r_k    <= '0;
            r_idx  <= '0;
          end
        end
        ST_RD_G: r_x <= bus.readIn[15:0];
        ST_RD_FP: begin
          if (r_k == '0) begin
            r_g   <= bus.readIn[15:0];
            r_acc <= (r_mode == MODE_COMPOSE) ? w_macOut : {r_x, 16'h0000};
          end
        end
        ST_RD_FG: r_fp <= bus.readIn[15:0];
        ST_MAC: begin
          r_acc <= w_macOut;
          r_k   <= r_k + 1'b1;
          r_idx <= r_idx + 1'b1;
        end
        ST_FIN: begin
          if (r_mode == MODE_EXTRACT) begin
            r_acc <= w_finAcc;
          end
        end
        ST_WR: begin
          r_k <= '0;
          if (r_j != J_LAST) begin
            r_j <= r_j + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsp_prev_engine.sv
// ---------------------------------------------------------------------------
// tb_lsp_prev_engine
// Directed bench for lsp_prev_engine: a default instance (M=10, NP=4,
// SHIFT=3) and a second instance (M=16, NP=2, SHIFT=2) share one
// behavioural scratch RAM. Expected values are hand-computed constants.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_lsp_prev_engine;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 32;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  lsp_prev_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busA ();
  lsp_prev_engine_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) busB ();

  lsp_prev_engine #(.M(10), .NP(4), .SHIFT(3), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dutA (
    .clk   (clk),
    .reset (reset),
    .bus   (busA.slave)
  );

  lsp_prev_engine #(.M(16), .NP(2), .SHIFT(2), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dutB (
    .clk   (clk),
    .reset (reset),
    .bus   (busB.slave)
  );

  logic [31:0] mem [0:2047];
  logic [31:0] res [0:2047];
  logic [10:0] wrLogA [0:255];
  logic [10:0] wrLogB [0:255];
  int wrCntA = 0;
  int wrCntB = 0;
  int checks = 0;
  int errors = 0;

  // Scratch RAM: registered reads for both engines, writes captured
  // into a separate result array plus an address log per engine.
  always @(posedge clk) begin
    busA.readIn <= mem[busA.readAddr];
    busB.readIn <= mem[busB.readAddr];
    if (busA.writeEn) begin
      res[busA.writeAddr]  <= busA.writeOut;
      wrLogA[wrCntA[7:0]]  <= busA.writeAddr;
      wrCntA               <= wrCntA + 1;
    end
    if (busB.writeEn) begin
      res[busB.writeAddr]  <= busB.writeOut;
      wrLogB[wrCntB[7:0]]  <= busB.writeAddr;
      wrCntB               <= wrCntB + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic fillRegion(input logic [10:0] base, input int count, input logic [31:0] value);
    for (int i = 0; i < count; i++) mem[base + 11'(i)] = value;
  endtask

  function automatic logic doneOf(input int sel);
    return (sel == 0) ? busA.done : busB.done;
  endfunction

  function automatic logic busyOf(input int sel);
    return (sel == 0) ? busA.busy : busB.busy;
  endfunction

  task automatic setStart(input int sel, input logic value);
    if (sel == 0) busA.start = value;
    else          busB.start = value;
  endtask

  // Drive bases and mode, pulse start for one cycle; returns #1 after
  // the accepting edge.
  task automatic applyStimulus(input int sel, input logic mode,
                               input logic [10:0] xb, input logic [10:0] gb,
                               input logic [10:0] fpb, input logic [10:0] fgb,
                               input logic [10:0] ob);
    if (sel == 0) begin
      busA.mode = mode; busA.x_base = xb; busA.g_base = gb;
      busA.fp_base = fpb; busA.fg_base = fgb; busA.out_base = ob;
    end else begin
      busB.mode = mode; busB.x_base = xb; busB.g_base = gb;
      busB.fp_base = fpb; busB.fg_base = fgb; busB.out_base = ob;
    end
    setStart(sel, 1'b1);
    tick();
    setStart(sel, 1'b0);
  endtask

  // Counts cycles from the accepting cycle (cycle 1 = first busy cycle)
  // until done; optionally pokes a stray start with toggled mode mid-run.
  task automatic waitDone(input int sel, input int pokeAt, output int cycles);
    int n = 1;
    while (!doneOf(sel) && n < 400) begin
      if (sel == 0 && n == pokeAt) begin
        busA.start = 1'b1;
        busA.mode  = ~busA.mode;
      end else if (sel == 0 && n == pokeAt + 1) begin
        busA.start = 1'b0;
      end
      tick();
      n++;
    end
    busA.start = 1'b0;
    cycles = n;
  endtask

  task automatic runAndCheck(input string tag, input int sel, input logic mode,
                             input logic [10:0] xb, input logic [10:0] gb,
                             input logic [10:0] fpb, input logic [10:0] fgb,
                             input logic [10:0] ob, input int pokeAt,
                             input logic [31:0] exp0, input logic [31:0] step);
    int cyc;
    int wb;
    int m;
    logic [10:0] a;
    logic [10:0] logged;
    m  = (sel == 0) ? 10 : 16;
    wb = (sel == 0) ? wrCntA : wrCntB;
    applyStimulus(sel, mode, xb, gb, fpb, fgb, ob);
    checkOutput({tag, " busy"}, 32'(busyOf(sel)), 32'd1);
    waitDone(sel, pokeAt, cyc);
    checkOutput({tag, " done cycle"}, cyc, 161);
    checkOutput({tag, " writes"}, ((sel == 0) ? wrCntA : wrCntB) - wb, m);
    for (int j = 0; j < m; j++) begin
      a      = ob + 11'(j);
      logged = (sel == 0) ? wrLogA[(wb + j) % 256] : wrLogB[(wb + j) % 256];
      checkOutput($sformatf("%s addr[%0d]", tag, j), 32'(logged), 32'(a));
      checkOutput($sformatf("%s out[%0d]", tag, j), res[a], exp0 + step * 32'(j));
    end
    // start raised during DONE must be ignored
    setStart(sel, 1'b1);
    tick();
    setStart(sel, 1'b0);
    checkOutput({tag, " start@done busy"}, 32'(busyOf(sel)), 32'd0);
    checkOutput({tag, " done pulse"}, 32'(doneOf(sel)), 32'd0);
  endtask

  initial begin
    int wb;
    int n;
    logic sawDone;

    reset = 1'b1;
    busA.start = 0; busA.mode = 0; busA.x_base = 0; busA.g_base = 0;
    busA.fp_base = 0; busA.fg_base = 0; busA.out_base = 0;
    busB.start = 0; busB.mode = 0; busB.x_base = 0; busB.g_base = 0;
    busB.fp_base = 0; busB.fg_base = 0; busB.out_base = 0;
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    tick();
    tick();

    $display("[TB] reset state");
    checkOutput("rst busy", 32'(busA.busy), 32'd0);
    checkOutput("rst done", 32'(busA.done), 32'd0);
    checkOutput("rst writeEn", 32'(busA.writeEn), 32'd0);
    checkOutput("rst readAddr", 32'(busA.readAddr), 32'd0);
    checkOutput("rst writeAddr", 32'(busA.writeAddr), 32'd0);
    checkOutput("rst writeOut", busA.writeOut, 32'd0);
    checkOutput("rst B busy", 32'(busB.busy), 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] extract basic with stray start mid-run");
    fillRegion(11'h000, 10, 32'h0000_1000);
    fillRegion(11'h010, 10, 32'h0000_4000);
    fillRegion(11'h020, 40, 32'h0000_0000);
    fillRegion(11'h060, 40, 32'h0000_1234);
    runAndCheck("ext", 0, 1'b0, 11'h000, 11'h010, 11'h020, 11'h060, 11'h100, 50,
                32'h0000_4000, 32'h0);

    $display("[TB] compose basic");
    fillRegion(11'h000, 10, 32'h0000_2000);
    fillRegion(11'h010, 10, 32'h0000_4000);
    fillRegion(11'h020, 40, 32'h0000_1000);
    fillRegion(11'h060, 40, 32'h0000_0800);
    runAndCheck("cmp", 0, 1'b1, 11'h000, 11'h010, 11'h020, 11'h060, 11'h120, 0,
                32'h0000_1400, 32'h0);

    $display("[TB] extract positive saturation");
    fillRegion(11'h000, 10, 32'h0000_7FFF);
    fillRegion(11'h010, 10, 32'h0000_7FFF);
    fillRegion(11'h020, 40, 32'hFFFF_8000);
    fillRegion(11'h060, 40, 32'h0000_7FFF);
    runAndCheck("extSat", 0, 1'b0, 11'h000, 11'h010, 11'h020, 11'h060, 11'h140, 0,
                32'h0000_7FFF, 32'h0);

    $display("[TB] extract negative saturation");
    fillRegion(11'h000, 10, 32'hFFFF_8000);
    fillRegion(11'h010, 10, 32'h0000_7FFF);
    fillRegion(11'h020, 40, 32'h0000_7FFF);
    fillRegion(11'h060, 40, 32'h0000_7FFF);
    runAndCheck("extNeg", 0, 1'b0, 11'h000, 11'h010, 11'h020, 11'h060, 11'h160, 0,
                32'hFFFF_8000, 32'h0);

    $display("[TB] compose saturation");
    fillRegion(11'h000, 10, 32'h0000_8000);
    fillRegion(11'h010, 10, 32'h0000_8000);
    fillRegion(11'h020, 40, 32'h0000_0000);
    fillRegion(11'h060, 40, 32'h0000_0000);
    runAndCheck("cmpSat", 0, 1'b1, 11'h000, 11'h010, 11'h020, 11'h060, 11'h180, 0,
                32'h0000_7FFF, 32'h0);

    $display("[TB] compose negative result sign extension");
    fillRegion(11'h000, 10, 32'h0000_2000);
    fillRegion(11'h010, 10, 32'h0000_C000);
    runAndCheck("cmpNeg", 0, 1'b1, 11'h000, 11'h010, 11'h020, 11'h060, 11'h1A0, 0,
                32'hFFFF_F000, 32'h0);

    $display("[TB] reset mid-run");
    fillRegion(11'h000, 10, 32'h0000_1000);
    fillRegion(11'h010, 10, 32'h0000_4000);
    wb = wrCntA;
    applyStimulus(0, 1'b0, 11'h000, 11'h010, 11'h020, 11'h060, 11'h1C0);
    n = 0;
    while ((wrCntA - wb) < 3 && n < 200) begin
      tick();
      n++;
    end
    checkOutput("rstRun three writes", wrCntA - wb, 3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checkOutput("rstRun busy", 32'(busA.busy), 32'd0);
    checkOutput("rstRun done", 32'(busA.done), 32'd0);
    checkOutput("rstRun writeEn", 32'(busA.writeEn), 32'd0);
    sawDone = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (busA.done) sawDone = 1'b1;
    end
    checkOutput("rstRun no more writes", wrCntA - wb, 3);
    checkOutput("rstRun no done", 32'(sawDone), 32'd0);
    runAndCheck("afterRst", 0, 1'b0, 11'h000, 11'h010, 11'h020, 11'h060, 11'h1E0, 0,
                32'h0000_4000, 32'h0);

    $display("[TB] parameter sweep M=16 NP=2 SHIFT=2");
    // fp[idx] = idx*0x100, fg = 0.5, x = g = 0 -> out[j] = 0x80 + j*0x200,
    // which only holds if fp/fg are fetched at j*2+k.
    fillRegion(11'h400, 16, 32'h0000_0000);
    fillRegion(11'h420, 16, 32'h0000_0000);
    for (int i = 0; i < 32; i++) mem[11'h440 + 11'(i)] = 32'(i) * 32'h100;
    fillRegion(11'h480, 32, 32'h0000_4000);
    runAndCheck("swpCmp", 1, 1'b1, 11'h400, 11'h420, 11'h440, 11'h480, 11'h500, 0,
                32'h0000_0080, 32'h0000_0200);

    fillRegion(11'h400, 16, 32'h0000_1000);
    fillRegion(11'h420, 16, 32'h0000_4000);
    fillRegion(11'h440, 32, 32'h0000_0000);
    runAndCheck("swpExt", 1, 1'b0, 11'h400, 11'h420, 11'h440, 11'h480, 11'h520, 0,
                32'h0000_2000, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
